// File: rtl/pos_decoder_pkg.sv
// rtl/pos_decoder_pkg.sv - shared widths, word type and position-to-one-hot decode.
package pos_decoder_pkg;

    localparam int POS_W = 2;
    localparam int VEC_W = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [VEC_W-1:0] onehot;
        logic [CNT_W-1:0] count;
    } word_t;

    function automatic logic [VEC_W-1:0] pos_to_onehot(input logic [POS_W-1:0] pos,
                                                       input logic             none);
        logic [VEC_W-1:0] vec;
        vec = '0;
        if (!none) begin
            vec[pos] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pos_decoder_buf.sv
// rtl/pos_decoder_buf.sv - 2-entry output buffer with registered ready.
module pos_decoder_buf
    import pos_decoder_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push_valid,
    output logic  in_ready,
    input  word_t push_word,
    output logic  out_valid,
    input  logic  out_ready,
    output word_t out_word
);

    logic [1:0] occ_q, occ_d;
    word_t      head_q, head_d;
    word_t      tail_q, tail_d;
    logic       rdy_q, rdy_d;
    logic       push, pop;

    // Ready depends only on next occupancy, so out_ready never reaches in_ready combinationally.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        push   = push_valid && rdy_q;
        pop    = (occ_q != 2'd0) && out_ready;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = push_word;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_word;
                end else if (push) begin
                    tail_d = push_word;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
        rdy_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            rdy_q  <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_word  = out_valid ? head_q : '0;

endmodule

// File: rtl/pos_decoder.sv
// rtl/pos_decoder.sv - position to one-hot decoder; POS_DECODER_ACCUM_EN enables frame accumulation.
module pos_decoder
    import pos_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POS_W-1:0] in_pos,
    input  logic             in_none,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_onehot,
    output logic [CNT_W-1:0] out_count
);

    logic [VEC_W-1:0] dec;
    logic             push_valid;
    word_t            push_word;
    word_t            out_word;

    assign dec = pos_to_onehot(in_pos, in_none);

`ifdef POS_DECODER_ACCUM_EN
    logic [VEC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beats_q, beats_d, beats_inc;
    logic             accept;

    // A frame only reaches the buffer on its last beat; earlier beats fold into the accumulator.
    always_comb begin
        accept           = in_valid && in_ready;
        beats_inc        = (beats_q == '1) ? beats_q : beats_q + CNT_W'(1);
        push_valid       = in_valid && in_last;
        push_word.onehot = acc_q | dec;
        push_word.count  = beats_inc;
        acc_d            = acc_q;
        beats_d          = beats_q;
        if (accept) begin
            if (in_last) begin
                acc_d   = '0;
                beats_d = '0;
            end else begin
                acc_d   = acc_q | dec;
                beats_d = beats_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            beats_q <= '0;
        end else begin
            acc_q   <= acc_d;
            beats_q <= beats_d;
        end
    end
`else
    logic unused_last;

    assign unused_last      = in_last;
    assign push_valid       = in_valid;
    assign push_word.onehot = dec;
    assign push_word.count  = CNT_W'(1);
`endif

    pos_decoder_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .in_ready   (in_ready),
        .push_word  (push_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word)
    );

    assign out_onehot = out_word.onehot;
    assign out_count  = out_word.count;

endmodule

// File: doc/pos_decoder.md
POS_DECODER -- requirements
Module: pos_decoder

Interface
REQ-001 Parameters: none; vector width fixed at 4, position width fixed at 2.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  input beat present.
REQ-005 in_ready  output  1  block accepts beat; transfer when in_valid && in_ready.
REQ-006 in_pos  input  2  bit position to re-expand, 0..3.
REQ-007 in_none  input  1  beat carries "no bit set"; in_pos ignored.
REQ-008 in_last  input  1  final beat of a frame; used only when the accumulate feature is compiled in.
REQ-009 out_valid  output  1  output word present.
REQ-010 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-011 out_onehot  output  4  decoded vector.
REQ-012 out_count  output  3  number of input beats merged into the word.

Function
REQ-013 Beat decode SHALL be 4'b0000 when in_none=1, else 1<<in_pos (0->0001, 1->0010, 2->0100, 3->1000).
REQ-014 Results SHALL pass through a 2-entry output buffer; out_onehot/out_count SHALL reflect the head entry while out_valid=1.
REQ-015 Latency: a beat pushed in cycle N into an empty buffer SHALL give out_valid=1 in cycle N+1.
REQ-016 in_ready SHALL be registered, =1 iff fewer than 2 entries held; no combinational path from out_ready to in_ready.
REQ-017 Simultaneous push and pop with 1 entry held SHALL keep occupancy at 1 and preserve order.
REQ-018 With 2 entries and out_ready=1, in_ready SHALL return to 1 in the following cycle; no beat SHALL be lost or duplicated.
REQ-019 out_onehot/out_count SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 When out_valid=0, out_onehot SHALL be 4'b0000 and out_count 0.

Reset
REQ-021 While reset=1: buffer empty, out_valid=0, out_onehot=0, out_count=0, in_ready=0, accumulator cleared.
REQ-022 First cycle after reset deasserts, in_ready SHALL be 1.
REQ-023 Reset mid-frame or with buffered words SHALL discard all pending data; nothing SHALL be emitted afterwards from it.

Configuration
REQ-024 Macro POS_DECODER_ACCUM_EN SHALL select frame accumulation.
REQ-025 Defined: each accepted beat SHALL OR its decode into a 4-bit accumulator and increment a beat counter saturating at 7; a beat with in_last=1 SHALL push (accumulator | decode, count) as one word, then clear both in the same cycle; a frame's final beat SHALL be accepted only when in_ready=1.
REQ-026 Undefined: every accepted beat SHALL push its decode with out_count=1; in_last SHALL be ignored; no accumulator registers SHALL exist.

Structure
REQ-027 Package pos_decoder_pkg SHALL hold POS_W=2, VEC_W=4, CNT_W=3 and a pure function pos_to_onehot(pos, none).
REQ-028 Sub-module pos_decoder_buf SHALL implement the 2-entry buffer with registered ready; pos_decoder SHALL instantiate it once.

Verification
REQ-029 Accumulate off: beats pos=0,1,2,3 with out_ready=1 -> words 0001,0010,0100,1000 each count 1, one cycle after each push.
REQ-030 Backpressure: out_ready=0, push pos=3, pos=1 -> in_ready=0 after second push; out_ready=1 -> 1000 then 0010, in_ready=1 next cycle.
REQ-031 in_none=1, in_pos=2 -> word 0000, count 1 (accumulate off).
REQ-032 Accumulate on: beats pos=0, none, pos=3 (last) -> single word 1001, count 3.
REQ-033 Accumulate on: 9 beats pos=1, last on 9th -> word 0010, count 7 (saturated).
REQ-034 Reset asserted after 2 beats of an open frame and 1 buffered word -> out_valid=0 next cycle; new frame pos=2 (last) -> 0100, count 1.
